pcie_lcrc_stream: RTL and testbench

Sequential, parametrised LCRC engine for the data link layer. It computes the 32-bit PCIe LCRC over a framed byte stream of any beat width (sequence number plus TLP bytes on transmit, or the full received frame including the trailing LCRC on receive). Each frame produces one result: the final LCRC value, and a residue-check flag for RX integrity checking. It sits between the DLLP/TLP framer and the replay buffer (TX) or the TLP receive path (RX).

---
 rtl/pcie_lcrc_stream.sv | 234 +++++++++++++++++++++++
 tb/tb_pcie_lcrc_stream.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_lcrc_stream.sv
// -----------------------------------------------------------------------------
// pcie_lcrc_stream
//
// Streaming 32-bit PCIe LCRC engine (CRC-32/ISO-HDLC) for the data link layer.
// Consumes a framed byte stream of DATA_W-bit beats and produces one result
// per frame: the final LCRC and a residue flag. The residue flag is set when
// the frame already carried its own correct LCRC, which is how RX checks
// integrity.
//
// Parameters
//   DATA_W : beat width in bits (32, 64 or 128)
//   REG_IN : 1 adds an input register stage (+1 cycle latency)
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   s_valid_i    input beat valid
//   s_ready_o    input beat accepted when s_valid_i & s_ready_o
//   s_data_i     beat bytes, [7:0] is the first byte on the wire
//   s_sop_i      first beat of frame
//   s_eop_i      last beat of frame
//   s_bytes_i    valid bytes on the eop beat (0 or >BYTES means BYTES)
//   crc_valid_o  result valid, held until crc_ready_i
//   crc_ready_i  result consumer ready
//   crc_o        final LCRC, crc_o[7:0] is the first LCRC byte transmitted
//   crc_ok_o     1 when crc_o equals the good residue 32'h2144DF1C
//   err_o        one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module pcie_lcrc_stream #(
   parameter int DATA_W = 32,
   parameter bit REG_IN = 1'b0
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              s_valid_i,
   output logic                              s_ready_o,
   input  logic [DATA_W-1:0]                 s_data_i,
   input  logic                              s_sop_i,
   input  logic                              s_eop_i,
   input  logic [$clog2(DATA_W/8):0]         s_bytes_i,
   output logic                              crc_valid_o,
   input  logic                              crc_ready_i,
   output logic [31:0]                       crc_o,
   output logic                              crc_ok_o,
   output logic                              err_o
);

   localparam int          BYTES   = DATA_W / 8;
   localparam int          BW      = $clog2(BYTES) + 1;
   localparam logic [31:0] SEED    = 32'hFFFF_FFFF;
   localparam logic [31:0] RESIDUE = 32'h2144_DF1C;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_RESULT
   } state_e;

   // One byte through the CRC, kept in unreflected (MSB-first) form. The
   // wire is LSB-first, so data bit 0 enters first.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[31] ^ b[i]) begin
            r = {r[30:0], 1'b0} ^ 32'h04C1_1DB7;
         end else begin
            r = {r[30:0], 1'b0};
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   state_e         state_q, state_d;
   logic [31:0]    run_q, run_d;
   logic [31:0]    crc_q, crc_d;
   logic           ok_q, ok_d;
   logic           err_q, err_d;

   logic           core_ready;
   logic           b_valid;
   logic [DATA_W-1:0] b_data;
   logic           b_sop;
   logic           b_eop;
   logic [BW-1:0]  b_bytes;
   logic           b_fire;

   // The core can take a beat whenever no result is pending or the pending
   // one is being consumed this cycle (back-to-back frames, no bubble).
   assign core_ready  = (state_q != ST_RESULT) | crc_ready_i;
   assign s_ready_o   = core_ready;
   assign crc_valid_o = (state_q == ST_RESULT);
   assign crc_o       = crc_q;
   assign crc_ok_o    = ok_q;
   assign err_o       = err_q;

   // ------------------------------------------------------------------------
   // Optional input stage. Loads only when s_ready_o is high, which is the
   // same condition under which the core drains it, so it never overflows
   // and the external handshake stays identical to the unregistered case.
   // ------------------------------------------------------------------------
   generate
      if (REG_IN) begin : g_reg_in
         logic              p_valid_q;
         logic [DATA_W-1:0] p_data_q;
         logic              p_sop_q;
         logic              p_eop_q;
         logic [BW-1:0]     p_bytes_q;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               p_valid_q <= 1'b0;
               p_data_q  <= '0;
               p_sop_q   <= 1'b0;
               p_eop_q   <= 1'b0;
               p_bytes_q <= '0;
            end else if (s_valid_i && core_ready) begin
               p_valid_q <= 1'b1;
               p_data_q  <= s_data_i;
               p_sop_q   <= s_sop_i;
               p_eop_q   <= s_eop_i;
               p_bytes_q <= s_bytes_i;
            end else if (core_ready) begin
               p_valid_q <= 1'b0;
            end
         end

         assign b_valid = p_valid_q;
         assign b_data  = p_data_q;
         assign b_sop   = p_sop_q;
         assign b_eop   = p_eop_q;
         assign b_bytes = p_bytes_q;
      end else begin : g_no_reg_in
         assign b_valid = s_valid_i;
         assign b_data  = s_data_i;
         assign b_sop   = s_sop_i;
         assign b_eop   = s_eop_i;
         assign b_bytes = s_bytes_i;
      end
   endgenerate

   assign b_fire = b_valid & core_ready;

   // ------------------------------------------------------------------------
   // Byte cascade: stage[k] is the CRC after the first k bytes of the beat.
   // ------------------------------------------------------------------------
   logic [BYTES:0][31:0] stage;
   logic [31:0]          sel_crc;
   logic [31:0]          fin_crc;

   assign stage[0] = b_sop ? SEED : run_q;

   generate
      for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte
         assign stage[gi+1] = crc_byte(stage[gi], b_data[8*gi +: 8]);
      end
   endgenerate

   // Partial last beat: pick the stage matching the byte count. Counts of 0
   // or above BYTES fall through to the full-beat stage.
   always_comb begin
      sel_crc = stage[BYTES];
      if (b_eop) begin
         for (int i = 1; i < BYTES; i++) begin
            if (b_bytes == BW'(i)) begin
               sel_crc = stage[i];
            end
         end
      end
   end

   // Reflect and complement to get the on-wire LCRC ordering.
   assign fin_crc = ~bitrev32(sel_crc);

   // ------------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      crc_d   = crc_q;
      ok_d    = ok_q;
      err_d   = 1'b0;

      if ((state_q == ST_RESULT) && crc_ready_i) begin
         state_d = ST_IDLE;
      end

      if (b_fire) begin
         // A fired beat in RESULT means the result is handshaking this
         // cycle, so it is treated exactly like a beat in IDLE.
         if ((state_q != ST_ACTIVE) && !b_sop) begin
            err_d = 1'b1;
         end else begin
            if ((state_q == ST_ACTIVE) && b_sop) begin
               err_d = 1'b1;
            end
            run_d = sel_crc;
            if (b_eop) begin
               state_d = ST_RESULT;
               crc_d   = fin_crc;
               ok_d    = (fin_crc == RESIDUE);
            end else begin
               state_d = ST_ACTIVE;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         run_q   <= SEED;
         crc_q   <= '0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         crc_q   <= crc_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_pcie_lcrc_stream.sv
// -----------------------------------------------------------------------------
// tb_pcie_lcrc_stream
//
// Directed bench for pcie_lcrc_stream. Three instances share one stimulus
// bus: 32-bit, 64-bit with input register, and 128-bit. 'sel' picks which
// instance receives beats and which one is observed.
// -----------------------------------------------------------------------------
module tb_pcie_lcrc_stream;

   logic         clk;
   logic         rst_n;
   logic [1:0]   sel;
   logic         s_valid;
   logic [127:0] s_data;
   logic         s_sop;
   logic         s_eop;
   logic [4:0]   s_bytes;
   logic         crc_ready;

   logic         rdy32, rdy64, rdy128;
   logic         cv32, cv64, cv128;
   logic [31:0]  crc32, crc64, crc128;
   logic         ok32, ok64, ok128;
   logic         er32, er64, er128;

   logic         s_ready;
   logic         crc_valid;
   logic [31:0]  crc;
   logic         crc_ok;
   logic         err;

   int n_checks;
   int n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pcie_lcrc_stream #(.DATA_W(32), .REG_IN(1'b0)) u_dut32 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .s_valid_i   (s_valid && (sel == 2'd0)),
      .s_ready_o   (rdy32),
      .s_data_i    (s_data[31:0]),
      .s_sop_i     (s_sop),
      .s_eop_i     (s_eop),
      .s_bytes_i   (s_bytes[2:0]),
      .crc_valid_o (cv32),
      .crc_ready_i (crc_ready),
      .crc_o       (crc32),
      .crc_ok_o    (ok32),
      .err_o       (er32)
   );

   pcie_lcrc_stream #(.DATA_W(64), .REG_IN(1'b1)) u_dut64 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .s_valid_i   (s_valid && (sel == 2'd1)),
      .s_ready_o   (rdy64),
      .s_data_i    (s_data[63:0]),
      .s_sop_i     (s_sop),
      .s_eop_i     (s_eop),
      .s_bytes_i   (s_bytes[3:0]),
      .crc_valid_o (cv64),
      .crc_ready_i (crc_ready),
      .crc_o       (crc64),
      .crc_ok_o    (ok64),
      .err_o       (er64)
   );

   pcie_lcrc_stream #(.DATA_W(128), .REG_IN(1'b0)) u_dut128 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .s_valid_i   (s_valid && (sel == 2'd2)),
      .s_ready_o   (rdy128),
      .s_data_i    (s_data),
      .s_sop_i     (s_sop),
      .s_eop_i     (s_eop),
      .s_bytes_i   (s_bytes),
      .crc_valid_o (cv128),
      .crc_ready_i (crc_ready),
      .crc_o       (crc128),
      .crc_ok_o    (ok128),
      .err_o       (er128)
   );

   always_comb begin
      case (sel)
         2'd1:    begin s_ready = rdy64;  crc_valid = cv64;  crc = crc64;  crc_ok = ok64;  err = er64;  end
         2'd2:    begin s_ready = rdy128; crc_valid = cv128; crc = crc128; crc_ok = ok128; err = er128; end
         default: begin s_ready = rdy32;  crc_valid = cv32;  crc = crc32;  crc_ok = ok32;  err = er32;  end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   // Present one beat and hold it until accepted; returns at posedge+1
   // of the accepting edge.
   task automatic send_beat(input logic [127:0] d, input logic sop, input logic eop,
                            input logic [4:0] nb);
      int t;
      s_data  = d;
      s_sop   = sop;
      s_eop   = eop;
      s_bytes = nb;
      s_valid = 1'b1;
      t = 0;
      while (!s_ready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 20) check("beat_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_sop   = 1'b0;
      s_eop   = 1'b0;
   endtask

   // Wait (bounded) for a result, compare it, then consume it.
   task automatic get_result(input string tag, input logic [31:0] exp_crc, input logic exp_ok);
      int t;
      t = 0;
      while (!crc_valid && t < 10) begin
         @(posedge clk); #1;
         t++;
      end
      check({tag, "_valid"}, {31'd0, crc_valid}, 32'd1);
      check({tag, "_crc"}, crc, exp_crc);
      check({tag, "_ok"}, {31'd0, crc_ok}, {31'd0, exp_ok});
      crc_ready = 1'b1;
      @(posedge clk); #1;
      crc_ready = 1'b0;
   endtask

   task automatic send_123456789_w32();
      send_beat(128'h34333231, 1'b1, 1'b0, 5'd4);
      send_beat(128'h38373635, 1'b0, 1'b0, 5'd4);
      send_beat(128'h00000039, 1'b0, 1'b1, 5'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      sel       = 2'd0;
      s_valid   = 1'b0;
      s_data    = '0;
      s_sop     = 1'b0;
      s_eop     = 1'b0;
      s_bytes   = '0;
      crc_ready = 1'b0;
      rst_n     = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, crc_valid}, 32'd0);
      check("rst_crc", crc, 32'd0);
      check("rst_ok", {31'd0, crc_ok}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", {31'd0, s_ready}, 32'd1);

      // 32-bit "123456789", result exactly one cycle after eop
      send_123456789_w32();
      check("w32_latency", {31'd0, crc_valid}, 32'd1);
      get_result("w32_check", 32'hCBF43926, 1'b0);

      // Frame carrying its own LCRC -> good residue
      send_beat(128'h34333231, 1'b1, 1'b0, 5'd4);
      send_beat(128'h38373635, 1'b0, 1'b0, 5'd4);
      send_beat(128'hF4392639, 1'b0, 1'b0, 5'd4);
      send_beat(128'h000000CB, 1'b0, 1'b1, 5'd1);
      get_result("w32_residue", 32'h2144DF1C, 1'b1);

      // Same frame with one flipped bit in the first byte
      send_beat(128'h34333230, 1'b1, 1'b0, 5'd4);
      send_beat(128'h38373635, 1'b0, 1'b0, 5'd4);
      send_beat(128'hF4392639, 1'b0, 1'b0, 5'd4);
      send_beat(128'h000000CB, 1'b0, 1'b1, 5'd1);
      n_checks++;
      if (!crc_valid || crc_ok || crc == 32'h2144DF1C) begin
         n_fail++;
         $display("FAIL w32_flip: got valid=%0d ok=%0d crc=%h expected valid=1 ok=0", crc_valid, crc_ok, crc);
      end else begin
         $display("ok   w32_flip: crc=%h", crc);
      end
      crc_ready = 1'b1;
      @(posedge clk); #1;
      crc_ready = 1'b0;

      // Backpressure: result held, input blocked
      send_123456789_w32();
      for (int i = 0; i < 5; i++) begin
         check("bp_ready", {31'd0, s_ready}, 32'd0);
         check("bp_crc", crc, 32'hCBF43926);
         @(posedge clk); #1;
      end
      // Consume result in the same cycle a new sop beat is presented
      crc_ready = 1'b1;
      s_data    = 128'h34333231;
      s_sop     = 1'b1;
      s_eop     = 1'b0;
      s_bytes   = 5'd4;
      s_valid   = 1'b1;
      #1;
      check("b2b_ready", {31'd0, s_ready}, 32'd1);
      @(posedge clk); #1;
      s_valid   = 1'b0;
      s_sop     = 1'b0;
      crc_ready = 1'b0;
      check("b2b_handshake", {31'd0, crc_valid}, 32'd0);
      send_beat(128'h38373635, 1'b0, 1'b0, 5'd4);
      send_beat(128'h00000039, 1'b0, 1'b1, 5'd1);
      get_result("b2b", 32'hCBF43926, 1'b0);

      // Non-sop beat in IDLE: error pulse, no result
      send_beat(128'h34333231, 1'b0, 1'b1, 5'd4);
      check("idle_nosop_err", {31'd0, err}, 32'd1);
      @(posedge clk); #1;
      check("idle_nosop_err_clr", {31'd0, err}, 32'd0);
      check("idle_nosop_noresult", {31'd0, crc_valid}, 32'd0);

      // sop mid-frame: restart, result covers only the new frame
      send_beat(128'h41414141, 1'b1, 1'b0, 5'd4);
      send_beat(128'h34333231, 1'b1, 1'b0, 5'd4);
      check("restart_err", {31'd0, err}, 32'd1);
      check("restart_noresult", {31'd0, crc_valid}, 32'd0);
      send_beat(128'h38373635, 1'b0, 1'b0, 5'd4);
      send_beat(128'h00000039, 1'b0, 1'b1, 5'd1);
      get_result("restart", 32'hCBF43926, 1'b0);

      // 64-bit with input register: single 0x00 byte, two-cycle latency
      sel = 2'd1;
      send_beat(128'h0, 1'b1, 1'b1, 5'd1);
      check("w64_lat_early", {31'd0, crc_valid}, 32'd0);
      @(posedge clk); #1;
      check("w64_lat", {31'd0, crc_valid}, 32'd1);
      get_result("w64_zero1", 32'hD202EF8D, 1'b0);
      send_beat(128'h0, 1'b1, 1'b1, 5'd4);
      get_result("w64_zero4", 32'h2144DF1C, 1'b1);

      // 128-bit: pending result cleared by asynchronous reset
      sel = 2'd2;
      send_beat(128'h00000000000000393837363534333231, 1'b1, 1'b1, 5'd9);
      check("w128_valid", {31'd0, crc_valid}, 32'd1);
      check("w128_crc", crc, 32'hCBF43926);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", {31'd0, crc_valid}, 32'd0);
      check("async_rst_crc", crc, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset mid-frame discards the frame
      send_beat(128'h55555555555555555555555555555555, 1'b1, 1'b0, 5'd16);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, crc_valid}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_ready", {31'd0, s_ready}, 32'd1);
      send_beat(128'h0000000000000000000000000000AAAA, 1'b0, 1'b1, 5'd2);
      check("mid_rst_discard_err", {31'd0, err}, 32'd1);
      check("mid_rst_noresult", {31'd0, crc_valid}, 32'd0);
      send_beat(128'h00000000000000393837363534333231, 1'b1, 1'b1, 5'd9);
      get_result("w128_after_rst", 32'hCBF43926, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
